inst_fetch_unit: RTL and testbench

Requester side of the instruction-memory interface: owns the PC, issues one fetch request per cycle to the fixed-latency instruction memory, collects its in-order responses, and presents instructions to the decode stage over a valid/ready handshake. The memory has no backpressure, so the block throttles requests against its own buffer space. Branch/jump redirects flush buffered instructions and squash in-flight responses.

---
 rtl/inst_fetch_unit.sv | 209 ++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Requester side of the instruction-memory interface. Owns the PC, issues at
// most one fetch per cycle to a fixed-latency, in-order instruction memory,
// buffers the returned instructions with their PCs in a small FIFO, and
// presents the FIFO head to decode over a valid/ready handshake. The memory
// cannot stall, so requests are only issued while the buffered entries plus
// the requests in flight still fit in the FIFO. A redirect flushes the FIFO,
// restarts fetch at the new PC, and marks every request still in flight as
// one whose response must be thrown away.
//
// Ports
//   i_clk            clock, all logic on the rising edge
//   i_rst            synchronous active-high reset
//   o_imem_valid     fetch request strobe (combinational from state, i_rst, i_redirect)
//   o_imem_addr      word-aligned request address (0 when no request)
//   i_imem_valid     response strobe, MEM_LAT cycles after the request
//   i_imem_inst      response instruction
//   i_redirect       redirect fetch; overrides every other event that cycle
//   i_redirect_pc    new PC; bits [1:0] are ignored
//   o_inst_valid     FIFO head valid (registered)
//   o_inst           FIFO head instruction (registered)
//   o_inst_pc        PC of the FIFO head instruction (registered)
//   i_inst_ready     decode accepts the head this cycle
//
// Build option
//   IFU_PERF_CNT_EN  when defined, adds o_fetch_cnt (issued requests) and
//                    o_squash_cnt (discarded responses, spurious ones
//                    included); both 32-bit, saturating, cleared by reset.
//
// FIFO_DEPTH must be a power of two and at least MEM_LAT+2, otherwise the
// throttle cannot sustain one instruction per cycle.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                INST_W     = 32,
    parameter int                MEM_LAT    = 3,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_valid,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [INST_W-1:0] i_imem_inst,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       o_fetch_cnt,
    output logic [31:0]       o_squash_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int SUM_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] PC_ALIGN_MASK    = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;
    localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(4);

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc;     // address of the next request
    logic [ADDR_W-1:0] resp_pc;      // PC owed to the next accepted response
    logic [OUT_W-1:0]  outstanding;  // requests issued, response not yet seen
    logic [OUT_W-1:0]  squash;       // in-flight responses still to be dropped
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [INST_W-1:0] fifo_inst [FIFO_DEPTH];

    // Per-cycle events
    logic              issue;
    logic              resp_ok;
    logic              discard;
    logic              push;
    logic              pop;
    logic [SUM_W-1:0]  occupancy;
    logic [ADDR_W-1:0] redirect_pc_aligned;

    // Next-cycle FIFO view used to load the registered head
    logic [CNT_W-1:0]  count_after_pop;
    logic [CNT_W-1:0]  next_count;
    logic [PTR_W-1:0]  next_rd_ptr;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;

    assign redirect_pc_aligned = i_redirect_pc & PC_ALIGN_MASK;

    // Every in-flight request already owns a FIFO slot, so the memory can
    // never deliver into a full buffer.
    assign occupancy    = SUM_W'(fifo_count) + SUM_W'(outstanding);
    assign issue        = !i_rst && !i_redirect && (occupancy < SUM_W'(FIFO_DEPTH));
    assign o_imem_valid = issue;
    assign o_imem_addr  = issue ? fetch_pc : '0;

    // A response with nothing outstanding is stray (e.g. from before a reset)
    // and must not disturb any counter.
    assign resp_ok = !i_rst && i_imem_valid && (outstanding != '0);
    assign discard = resp_ok && ((squash != '0) || i_redirect);
    assign push    = resp_ok && !discard;
    assign pop     = o_inst_valid && i_inst_ready;

    // NOTE: every always_comb output gets a value on every path; a missing
    // else here would silently infer a latch.
    always_comb begin
        count_after_pop = fifo_count - CNT_W'(pop);
        next_count      = count_after_pop + CNT_W'(push);
        next_rd_ptr     = rd_ptr + PTR_W'(pop);
        if (count_after_pop == '0) begin
            // Buffer drains this cycle: the new head is the entry being pushed.
            head_pc   = resp_pc;
            head_inst = i_imem_inst;
        end else begin
            head_pc   = fifo_pc[next_rd_ptr];
            head_inst = fifo_inst[next_rd_ptr];
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc     <= RESET_PC_ALIGNED;
            resp_pc      <= RESET_PC_ALIGNED;
            outstanding  <= '0;
            squash       <= '0;
            fifo_count   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_inst_valid <= 1'b0;
            o_inst       <= '0;
            o_inst_pc    <= '0;
        end else if (i_redirect) begin
            fetch_pc     <= redirect_pc_aligned;
            resp_pc      <= redirect_pc_aligned;
            // Nothing issues this cycle, so whatever stays outstanding after
            // this cycle's response belongs to the old stream.
            outstanding  <= outstanding - OUT_W'(resp_ok);
            squash       <= outstanding - OUT_W'(resp_ok);
            fifo_count   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_inst_valid <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            outstanding <= outstanding + OUT_W'(issue) - OUT_W'(resp_ok);
            if (discard) begin
                squash <= squash - OUT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + PC_STEP;
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            rd_ptr       <= next_rd_ptr;
            fifo_count   <= next_count;
            o_inst_valid <= (next_count != '0);
            if (next_count != '0) begin
                o_inst    <= head_inst;
                o_inst_pc <= head_pc;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; fifo_count and the pointers decide
    // which entries are meaningful, so clearing the array would only cost logic.
    always_ff @(posedge i_clk) begin
        if (push && !i_redirect) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= i_imem_inst;
        end
    end

    // The issue throttle makes overflow impossible; catch it if that breaks.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_redirect) begin
            assert (!(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fetch_cnt  <= '0;
            o_squash_cnt <= '0;
        end else begin
            if (issue && (o_fetch_cnt != '1)) begin
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
            // Anything the memory returned that did not enter the FIFO.
            if (i_imem_valid && !push && (o_squash_cnt != '1)) begin
                o_squash_cnt <= o_squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit with a MEM_LAT-deep memory model whose
// word k holds the value k. Inputs change on the falling edge; outputs are
// sampled 1 time unit later. Cycle k of a scenario is the clock period in
// which the k-th falling-edge stimulus is applied (cycle 0 = first cycle with
// i_rst low).
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    localparam int ADDR_W     = 64;
    localparam int INST_W     = 32;
    localparam int MEM_LAT    = 3;
    localparam int FIFO_DEPTH = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              o_imem_valid;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_valid;
    logic [INST_W-1:0] i_imem_inst;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic              o_inst_valid;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_pc;
    logic              i_inst_ready;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]       o_fetch_cnt;
    logic [31:0]       o_squash_cnt;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 i_clk = ~i_clk;

    inst_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .INST_W    (INST_W),
        .MEM_LAT   (MEM_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RESET_PC  (64'h0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_imem_valid (o_imem_valid),
        .o_imem_addr  (o_imem_addr),
        .i_imem_valid (i_imem_valid),
        .i_imem_inst  (i_imem_inst),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .i_inst_ready (i_inst_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .o_fetch_cnt  (o_fetch_cnt),
        .o_squash_cnt (o_squash_cnt)
`endif
    );

    // Fixed-latency memory: mem[addr>>2] = addr>>2. Never reset, so requests
    // in flight across a DUT reset still come back.
    logic [MEM_LAT-1:0] mem_pipe_v = '0;
    logic [ADDR_W-1:0]  mem_pipe_a [MEM_LAT];

    always @(posedge i_clk) begin
        mem_pipe_v    <= {mem_pipe_v[MEM_LAT-2:0], o_imem_valid};
        mem_pipe_a[0] <= o_imem_addr;
        for (int i = 1; i < MEM_LAT; i++) mem_pipe_a[i] <= mem_pipe_a[i-1];
    end

    assign i_imem_valid = mem_pipe_v[MEM_LAT-1];
    assign i_imem_inst  = INST_W'(mem_pipe_a[MEM_LAT-1] >> 2);

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_rst         = 1'b1;
            i_redirect    = 1'b0;
            i_redirect_pc = '0;
            i_inst_ready  = 1'b1;
        end
    endtask

    task automatic test_reset();
        apply_reset(4);
        @(negedge i_clk);
        #1;
        n_compared++;
        if (o_imem_valid !== 1'b0 || o_imem_addr !== 64'h0) begin
            n_mismatched++;
            $display("FAIL reset_req got v=%0b addr=%h exp v=0 addr=0", o_imem_valid, o_imem_addr);
        end
        n_compared++;
        if (o_inst_valid !== 1'b0 || o_inst !== 32'h0 || o_inst_pc !== 64'h0) begin
            n_mismatched++;
            $display("FAIL reset_out got v=%0b inst=%h pc=%h exp v=0 inst=0 pc=0",
                     o_inst_valid, o_inst, o_inst_pc);
        end
`ifdef IFU_PERF_CNT_EN
        n_compared++;
        if (o_fetch_cnt !== 32'd0 || o_squash_cnt !== 32'd0) begin
            n_mismatched++;
            $display("FAIL reset_cnt got fetch=%0d squash=%0d exp 0 0", o_fetch_cnt, o_squash_cnt);
        end
`endif
    endtask

    // Ready held high: a request every cycle, first instruction in cycle 4.
    task automatic test_fetch_stream();
        logic rv; logic [63:0] ra; logic ov; logic [31:0] oi; logic [63:0] op;
        apply_reset(4);
        for (int k = 0; k < 16; k++) begin
            @(negedge i_clk);
            i_rst = 1'b0;
            i_inst_ready = 1'b1;
            #1;
            rv = 1'b1; ra = 64'(4 * k);
            ov = (k >= 4); oi = 32'(k - 4); op = 64'(4 * (k - 4));
            n_compared++;
            if (o_imem_valid !== rv || (rv && o_imem_addr !== ra)) begin
                n_mismatched++;
                $display("FAIL stream_req k=%0d got v=%0b addr=%h exp v=%0b addr=%h", k, o_imem_valid, o_imem_addr, rv, ra);
            end
            n_compared++;
            if (o_inst_valid !== ov || (ov && (o_inst !== oi || o_inst_pc !== op))) begin
                n_mismatched++;
                $display("FAIL stream_out k=%0d got v=%0b inst=%h pc=%h exp v=%0b inst=%h pc=%h",
                         k, o_inst_valid, o_inst, o_inst_pc, ov, oi, op);
            end
`ifdef IFU_PERF_CNT_EN
            if (k == 15) begin
                n_compared++;
                if (o_fetch_cnt !== 32'd15 || o_squash_cnt !== 32'd0) begin
                    n_mismatched++;
                    $display("FAIL stream_cnt got fetch=%0d squash=%0d exp 15 0", o_fetch_cnt, o_squash_cnt);
                end
            end
`endif
        end
    endtask

    // Ready low: 8 requests fill the FIFO, then fetch stalls; ready raised in
    // cycle 14 drains one per cycle and fetch resumes in cycle 15.
    task automatic test_backpressure();
        logic rv; logic [63:0] ra; logic ov; logic [31:0] oi; logic [63:0] op;
        apply_reset(4);
        for (int k = 0; k < 26; k++) begin
            @(negedge i_clk);
            i_rst = 1'b0;
            i_inst_ready = (k >= 14);
            #1;
            rv = (k <= 7) || (k >= 15);
            ra = (k <= 7) ? 64'(4 * k) : 64'(4 * (k - 7));
            ov = (k >= 4);
            oi = (k < 14) ? 32'h0 : 32'(k - 14);
            op = (k < 14) ? 64'h0 : 64'(4 * (k - 14));
            n_compared++;
            if (o_imem_valid !== rv || (rv && o_imem_addr !== ra)) begin
                n_mismatched++;
                $display("FAIL bp_req k=%0d got v=%0b addr=%h exp v=%0b addr=%h", k, o_imem_valid, o_imem_addr, rv, ra);
            end
            n_compared++;
            if (o_inst_valid !== ov || (ov && (o_inst !== oi || o_inst_pc !== op))) begin
                n_mismatched++;
                $display("FAIL bp_out k=%0d got v=%0b inst=%h pc=%h exp v=%0b inst=%h pc=%h",
                         k, o_inst_valid, o_inst, o_inst_pc, ov, oi, op);
            end
        end
    endtask

    // Redirect to 0x103 in cycle 6 with 3 requests in flight.
    task automatic test_redirect();
        logic rv; logic [63:0] ra; logic ov; logic [31:0] oi; logic [63:0] op;
        apply_reset(4);
        for (int k = 0; k < 14; k++) begin
            @(negedge i_clk);
            i_rst = 1'b0;
            i_inst_ready = 1'b1;
            i_redirect = (k == 6);
            i_redirect_pc = 64'h103;
            #1;
            rv = (k != 6);
            ra = (k < 6) ? 64'(4 * k) : 64'h100 + 64'(4 * (k - 7));
            ov = (k >= 4 && k <= 6) || (k >= 11);
            oi = (k <= 6) ? 32'(k - 4) : 32'h40 + 32'(k - 11);
            op = (k <= 6) ? 64'(4 * (k - 4)) : 64'h100 + 64'(4 * (k - 11));
            n_compared++;
            if (o_imem_valid !== rv || (rv && o_imem_addr !== ra)) begin
                n_mismatched++;
                $display("FAIL redir_req k=%0d got v=%0b addr=%h exp v=%0b addr=%h", k, o_imem_valid, o_imem_addr, rv, ra);
            end
            n_compared++;
            if (o_inst_valid !== ov || (ov && (o_inst !== oi || o_inst_pc !== op))) begin
                n_mismatched++;
                $display("FAIL redir_out k=%0d got v=%0b inst=%h pc=%h exp v=%0b inst=%h pc=%h",
                         k, o_inst_valid, o_inst, o_inst_pc, ov, oi, op);
            end
        end
    endtask

    // FIFO filled under backpressure, drained with ready=1, then a redirect
    // to 0x200 in cycle 18 coincides with a response (squash = 3-1 = 2).
    task automatic test_redirect_full();
        logic rv; logic [63:0] ra; logic ov; logic [31:0] oi; logic [63:0] op;
        apply_reset(4);
        for (int k = 0; k < 26; k++) begin
            @(negedge i_clk);
            i_rst = 1'b0;
            i_inst_ready = (k >= 14);
            i_redirect = (k == 18);
            i_redirect_pc = 64'h200;
            #1;
            rv = (k <= 7) || (k >= 15 && k != 18);
            ra = (k <= 7) ? 64'(4 * k) : (k < 18) ? 64'(4 * (k - 7)) : 64'h200 + 64'(4 * (k - 19));
            ov = (k >= 4 && k <= 18) || (k >= 23);
            oi = (k < 14) ? 32'h0 : (k <= 18) ? 32'(k - 14) : 32'h80 + 32'(k - 23);
            op = (k < 14) ? 64'h0 : (k <= 18) ? 64'(4 * (k - 14)) : 64'h200 + 64'(4 * (k - 23));
            n_compared++;
            if (o_imem_valid !== rv || (rv && o_imem_addr !== ra)) begin
                n_mismatched++;
                $display("FAIL rfull_req k=%0d got v=%0b addr=%h exp v=%0b addr=%h", k, o_imem_valid, o_imem_addr, rv, ra);
            end
            n_compared++;
            if (o_inst_valid !== ov || (ov && (o_inst !== oi || o_inst_pc !== op))) begin
                n_mismatched++;
                $display("FAIL rfull_out k=%0d got v=%0b inst=%h pc=%h exp v=%0b inst=%h pc=%h",
                         k, o_inst_valid, o_inst, o_inst_pc, ov, oi, op);
            end
        end
    endtask

    // Redirect to 0x40 in cycle 6 then to 0x80 in cycle 7: only 0x80 survives.
    task automatic test_back_to_back();
        logic rv; logic [63:0] ra; logic ov; logic [31:0] oi; logic [63:0] op;
        apply_reset(4);
        for (int k = 0; k < 15; k++) begin
            @(negedge i_clk);
            i_rst = 1'b0;
            i_inst_ready = 1'b1;
            i_redirect = (k == 6) || (k == 7);
            i_redirect_pc = (k == 6) ? 64'h40 : 64'h80;
            #1;
            rv = (k < 6) || (k >= 8);
            ra = (k < 6) ? 64'(4 * k) : 64'h80 + 64'(4 * (k - 8));
            ov = (k >= 4 && k <= 6) || (k >= 12);
            oi = (k <= 6) ? 32'(k - 4) : 32'h20 + 32'(k - 12);
            op = (k <= 6) ? 64'(4 * (k - 4)) : 64'h80 + 64'(4 * (k - 12));
            n_compared++;
            if (o_imem_valid !== rv || (rv && o_imem_addr !== ra)) begin
                n_mismatched++;
                $display("FAIL b2b_req k=%0d got v=%0b addr=%h exp v=%0b addr=%h", k, o_imem_valid, o_imem_addr, rv, ra);
            end
            n_compared++;
            if (o_inst_valid !== ov || (ov && (o_inst !== oi || o_inst_pc !== op))) begin
                n_mismatched++;
                $display("FAIL b2b_out k=%0d got v=%0b inst=%h pc=%h exp v=%0b inst=%h pc=%h",
                         k, o_inst_valid, o_inst, o_inst_pc, ov, oi, op);
            end
        end
    endtask

    // Reset pulsed in cycles 8-9 while the memory is still returning; the
    // response landing in cycle 10 sees nothing outstanding and is dropped.
    task automatic test_reset_midstream();
        logic rv; logic [63:0] ra; logic ov; logic [31:0] oi; logic [63:0] op; logic full;
        apply_reset(4);
        for (int k = 0; k < 17; k++) begin
            @(negedge i_clk);
            i_rst = (k == 8) || (k == 9);
            i_inst_ready = 1'b1;
            #1;
            rv = (k < 8) || (k >= 10);
            ra = (k < 8) ? 64'(4 * k) : (k < 10) ? 64'h0 : 64'(4 * (k - 10));
            ov = (k >= 4 && k <= 8) || (k >= 14);
            oi = (k <= 8) ? 32'(k - 4) : (k < 14) ? 32'h0 : 32'(k - 14);
            op = (k <= 8) ? 64'(4 * (k - 4)) : (k < 14) ? 64'h0 : 64'(4 * (k - 14));
            full = ov || (k == 9) || (k == 10);
            n_compared++;
            if (o_imem_valid !== rv || ((rv || k == 8 || k == 9) && o_imem_addr !== ra)) begin
                n_mismatched++;
                $display("FAIL rstmid_req k=%0d got v=%0b addr=%h exp v=%0b addr=%h", k, o_imem_valid, o_imem_addr, rv, ra);
            end
            n_compared++;
            if (o_inst_valid !== ov || (full && (o_inst !== oi || o_inst_pc !== op))) begin
                n_mismatched++;
                $display("FAIL rstmid_out k=%0d got v=%0b inst=%h pc=%h exp v=%0b inst=%h pc=%h",
                         k, o_inst_valid, o_inst, o_inst_pc, ov, oi, op);
            end
`ifdef IFU_PERF_CNT_EN
            if (k == 10) begin
                n_compared++;
                if (o_fetch_cnt !== 32'd0 || o_squash_cnt !== 32'd0) begin
                    n_mismatched++;
                    $display("FAIL rstmid_cnt got fetch=%0d squash=%0d exp 0 0", o_fetch_cnt, o_squash_cnt);
                end
            end
`endif
        end
    endtask

    initial begin
        i_rst         = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_inst_ready  = 1'b0;

        test_reset();
        test_fetch_stream();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_reset_midstream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the scenarios completed");
        $fatal(1, "watchdog");
    end

endmodule
